quad_core_fetch_unit: RTL and testbench

//  Per-core instruction fetch stage for the 4-core parallel processor. It sits upstream of the shared 4-port 16-bit program RAM.
//  It drives one read address per core and captures the combinational read word in the same cycle.
//  It buffers the fetched words in a small per-core queue and hands them to each core's decode stage over a valid/ready handshake.
//  It detects the halt word and stops that core's fetch.

---
 rtl/quad_core_fetch_unit_if.sv | 38 +++
 rtl/quad_core_fetch_unit.sv | 125 ++++++++++++
 tb/tb_quad_core_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/quad_core_fetch_unit_if.sv
// Fetch-unit bus bundle: per-core control, the four RAM read ports and the decode handshake.
// master = fetch unit side, slave = cores/RAM side.
interface quad_core_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [3:0]          start;
    logic [4*ADDR_W-1:0] start_pc;
    logic [3:0]          redirect;
    logic [4*ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0]   address0;
    logic [ADDR_W-1:0]   address1;
    logic [ADDR_W-1:0]   address2;
    logic [ADDR_W-1:0]   address3;
    logic [DATA_W-1:0]   dataout0;
    logic [DATA_W-1:0]   dataout1;
    logic [DATA_W-1:0]   dataout2;
    logic [DATA_W-1:0]   dataout3;
    logic [3:0]          instr_valid;
    logic [3:0]          instr_ready;
    logic [4*DATA_W-1:0] instr_data;
    logic [4*ADDR_W-1:0] instr_pc;
    logic [3:0]          halted;

    modport master (
        input  start, start_pc, redirect, redirect_pc,
        input  dataout0, dataout1, dataout2, dataout3, instr_ready,
        output address0, address1, address2, address3,
        output instr_valid, instr_data, instr_pc, halted
    );

    modport slave (
        output start, start_pc, redirect, redirect_pc,
        output dataout0, dataout1, dataout2, dataout3, instr_ready,
        input  address0, address1, address2, address3,
        input  instr_valid, instr_data, instr_pc, halted
    );
endinterface

// File: rtl/quad_core_fetch_unit.sv
// Four independent fetch engines: pc drives the RAM port, the word is queued the same cycle.
// Latency 1 cycle pc-to-decode; a full queue stalls fetch unless its head pops that cycle.
module quad_core_fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [DATA_W-1:0] HALT_WORD  = {DATA_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    quad_core_fetch_unit_if.master  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    logic [4*DATA_W-1:0] rdata_flat;
    logic [4*ADDR_W-1:0] addr_flat;
    logic [4*DATA_W-1:0] data_flat;
    logic [4*ADDR_W-1:0] ipc_flat;
    logic [3:0]          valid_w;
    logic [3:0]          halted_w;

    assign rdata_flat    = {bus.dataout3, bus.dataout2, bus.dataout1, bus.dataout0};
    assign bus.address0  = addr_flat[0*ADDR_W +: ADDR_W];
    assign bus.address1  = addr_flat[1*ADDR_W +: ADDR_W];
    assign bus.address2  = addr_flat[2*ADDR_W +: ADDR_W];
    assign bus.address3  = addr_flat[3*ADDR_W +: ADDR_W];
    assign bus.instr_valid = valid_w;
    assign bus.instr_data  = data_flat;
    assign bus.instr_pc    = ipc_flat;
    assign bus.halted      = halted_w;

    for (genvar g = 0; g < 4; g++) begin : g_core
        state_t             state_q, state_d;
        logic [ADDR_W-1:0]  pc_q, pc_d;
        logic               halted_q, halted_d;
        logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [DATA_W-1:0]  mem_dat_q [FIFO_DEPTH];
        logic [ADDR_W-1:0]  mem_pc_q  [FIFO_DEPTH];
        logic [DATA_W-1:0]  rdata;
        logic               load, pop, accept, push;
        logic [ADDR_W-1:0]  load_pc;

        assign rdata = rdata_flat[g*DATA_W +: DATA_W];

        always_comb begin
            state_d  = state_q;
            pc_d     = pc_q;
            halted_d = halted_q;
            rd_d     = rd_q;
            wr_d     = wr_q;
            cnt_d    = cnt_q;
            push     = 1'b0;
            load     = bus.start[g] | bus.redirect[g];
            load_pc  = bus.start[g] ? bus.start_pc[g*ADDR_W +: ADDR_W]
                                    : bus.redirect_pc[g*ADDR_W +: ADDR_W];
            pop      = (cnt_q != '0) && bus.instr_ready[g];
            accept   = (state_q == FETCH) && ((cnt_q < FULL) || pop);
            // A (re)start discards this cycle's fetched word and any pop along with the queue.
            if (load) begin
                state_d  = FETCH;
                pc_d     = load_pc;
                halted_d = 1'b0;
                rd_d     = '0;
                wr_d     = '0;
                cnt_d    = '0;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (accept) begin
                            if (rdata == HALT_WORD) begin
                                state_d  = HALTED;
                                halted_d = 1'b1;
                            end else begin
                                push = 1'b1;
                                pc_d = pc_q + ADDR_W'(1);
                            end
                        end
                    end
                    IDLE, HALTED: ;
                    default: state_d = IDLE;
                endcase
                if (push) wr_d = wr_q + PTR_W'(1);
                if (pop)  rd_d = rd_q + PTR_W'(1);
                cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= IDLE;
                pc_q     <= '0;
                halted_q <= 1'b0;
                rd_q     <= '0;
                wr_q     <= '0;
                cnt_q    <= '0;
            end else begin
                state_q  <= state_d;
                pc_q     <= pc_d;
                halted_q <= halted_d;
                rd_q     <= rd_d;
                wr_q     <= wr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_dat_q[wr_q] <= rdata;
                mem_pc_q[wr_q]  <= pc_q;
            end
        end

        assign addr_flat[g*ADDR_W +: ADDR_W] = pc_q;
        assign valid_w[g]  = (cnt_q != '0);
        assign halted_w[g] = halted_q;
        assign data_flat[g*DATA_W +: DATA_W] = valid_w[g] ? mem_dat_q[rd_q] : '0;
        assign ipc_flat[g*ADDR_W +: ADDR_W]  = valid_w[g] ? mem_pc_q[rd_q]  : '0;
    end

endmodule

// File: tb/tb_quad_core_fetch_unit.sv
// Directed bench for quad_core_fetch_unit with a behavioural 4-port RAM and per-step expected values.
module tb_quad_core_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] ram [65536];
    int   idx [4];

    always #5 clk = ~clk;

    quad_core_fetch_unit_if bus ();

    quad_core_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dataout0 = ram[bus.address0];
    assign bus.dataout1 = ram[bus.address1];
    assign bus.dataout2 = ram[bus.address2];
    assign bus.dataout3 = ram[bus.address3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input int n, input string tag, input logic [15:0] d, input logic [15:0] pc);
        chk({tag, "_valid"}, 64'(bus.instr_valid[n]), 64'd1);
        chk({tag, "_data"},  64'(bus.instr_data[n*16 +: 16]), 64'(d));
        chk({tag, "_pc"},    64'(bus.instr_pc[n*16 +: 16]), 64'(pc));
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
        reset = 1'b1;
        bus.start = '0; bus.start_pc = '0; bus.redirect = '0; bus.redirect_pc = '0;
        bus.instr_ready = 4'hF;
        step(); step();
        chk("rst_valid", 64'(bus.instr_valid), 64'h0);
        chk("rst_halted", 64'(bus.halted), 64'h0);
        chk("rst_data", 64'(bus.instr_data), 64'h0);
        chk("rst_ipc", 64'(bus.instr_pc), 64'h0);
        chk("rst_addr", {bus.address3, bus.address2, bus.address1, bus.address0}, 64'h0);
        reset = 1'b0;

        // 1: core0 straight-line program ending in halt
        ram[0] = 16'h0000; ram[1] = 16'h0001; ram[2] = 16'h8002; ram[3] = 16'hFFFF;
        bus.start = 4'b0001; bus.start_pc[15:0] = 16'h0000;
        step(); bus.start = '0;
        chk("t1_addr0", 64'(bus.address0), 64'h0);
        chk("t1_novalid", 64'(bus.instr_valid[0]), 64'd0);
        step(); head(0, "t1_w0", 16'h0000, 16'h0000);
        step(); head(0, "t1_w1", 16'h0001, 16'h0001);
        step(); head(0, "t1_w2", 16'h8002, 16'h0002);
        step();
        chk("t1_valid_end", 64'(bus.instr_valid[0]), 64'd0);
        chk("t1_halted", 64'(bus.halted[0]), 64'd1);
        step();
        chk("t1_addr_hold", 64'(bus.address0), 64'h3);
        chk("t1_halted_hold", 64'(bus.halted[0]), 64'd1);

        // 2: core1 pc wrap
        ram[16'hFFFE] = 16'h1234; ram[16'hFFFF] = 16'h5678; ram[0] = 16'hFFFF;
        bus.start = 4'b0010; bus.start_pc[31:16] = 16'hFFFE;
        step(); bus.start = '0;
        chk("t2_addr", 64'(bus.address1), 64'hFFFE);
        step(); head(1, "t2_w0", 16'h1234, 16'hFFFE);
        step(); head(1, "t2_w1", 16'h5678, 16'hFFFF);
        chk("t2_wrap", 64'(bus.address1), 64'h0000);
        step();
        chk("t2_halted", 64'(bus.halted[1]), 64'd1);
        chk("t2_valid_end", 64'(bus.instr_valid[1]), 64'd0);

        // 3: core2 backpressure
        for (int i = 0; i < 8; i++) ram[16'h0100 + i] = 16'h2000 + 16'(i);
        ram[16'h0108] = 16'hFFFF;
        bus.instr_ready[2] = 1'b0;
        bus.start = 4'b0100; bus.start_pc[47:32] = 16'h0100;
        step(); bus.start = '0;
        for (int i = 0; i < 5; i++) step();
        head(2, "t3_stall", 16'h2000, 16'h0100);
        chk("t3_pc_sat", 64'(bus.address2), 64'h0102);
        bus.instr_ready[2] = 1'b1;
        step(); head(2, "t3_r1", 16'h2001, 16'h0101);
        step(); head(2, "t3_r2", 16'h2002, 16'h0102);
        step(); head(2, "t3_r3", 16'h2003, 16'h0103);

        // 4: core3 redirect on a full queue with a simultaneous pop
        ram[16'h0200] = 16'h3000; ram[16'h0201] = 16'h3001; ram[16'h0202] = 16'h3002;
        ram[16'h0040] = 16'h4040; ram[16'h0041] = 16'h4041; ram[16'h0042] = 16'hFFFF;
        bus.instr_ready[3] = 1'b0;
        bus.start = 4'b1000; bus.start_pc[63:48] = 16'h0200;
        step(); bus.start = '0;
        step(); step(); step();
        head(3, "t4_full", 16'h3000, 16'h0200);
        chk("t4_addr_full", 64'(bus.address3), 64'h0202);
        bus.redirect = 4'b1000; bus.redirect_pc[63:48] = 16'h0040; bus.instr_ready[3] = 1'b1;
        step(); bus.redirect = '0;
        chk("t4_flushed", 64'(bus.instr_valid[3]), 64'd0);
        chk("t4_addr_redir", 64'(bus.address3), 64'h0040);
        step(); head(3, "t4_w0", 16'h4040, 16'h0040);
        step(); head(3, "t4_w1", 16'h4041, 16'h0041);
        step();
        chk("t4_halted", 64'(bus.halted[3]), 64'd1);

        // 5: all cores together, random ready
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 6; i++) ram[16'h1000 * (n + 1) + i] = {4'(n), 12'(i)};
            ram[16'h1000 * (n + 1) + 6] = 16'hFFFF;
            bus.start_pc[n*16 +: 16] = 16'h1000 * 16'(n + 1);
            idx[n] = 0;
        end
        bus.start = 4'hF;
        step(); bus.start = '0;
        for (int c = 0; c < 80; c++) begin
            bus.instr_ready = 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                if (bus.instr_valid[n] && bus.instr_ready[n]) begin
                    chk("t5_word", {bus.instr_data[n*16 +: 16], bus.instr_pc[n*16 +: 16]},
                        64'({4'(n), 12'(idx[n]), 16'h1000 * 16'(n + 1) + 16'(idx[n])}));
                    idx[n]++;
                end
            end
            step();
        end
        for (int n = 0; n < 4; n++) chk("t5_count", 64'(idx[n]), 64'd6);
        chk("t5_halted", 64'(bus.halted), 64'hF);
        bus.instr_ready = 4'hF;

        // 6: reset mid-fetch, then restart out of HALTED without reset
        bus.start = 4'hF;
        step(); bus.start = '0;
        step();
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t6_valid", 64'(bus.instr_valid), 64'h0);
        chk("t6_halted", 64'(bus.halted), 64'h0);
        chk("t6_data", 64'(bus.instr_data), 64'h0);
        chk("t6_ipc", 64'(bus.instr_pc), 64'h0);
        chk("t6_addr", {bus.address3, bus.address2, bus.address1, bus.address0}, 64'h0);
        step(); step();
        chk("t6_idle_valid", 64'(bus.instr_valid), 64'h0);
        chk("t6_idle_addr", {bus.address3, bus.address2, bus.address1, bus.address0}, 64'h0);
        ram[16'h0500] = 16'hFFFF;
        ram[16'h0600] = 16'h6600; ram[16'h0601] = 16'hFFFF; ram[16'h0700] = 16'h7700;
        bus.start = 4'b0001; bus.start_pc[15:0] = 16'h0500;
        step(); bus.start = '0;
        step();
        chk("t6_halt_again", 64'(bus.halted[0]), 64'd1);
        bus.start = 4'b0001; bus.start_pc[15:0] = 16'h0600;
        bus.redirect = 4'b0001; bus.redirect_pc[15:0] = 16'h0700;
        step(); bus.start = '0; bus.redirect = '0;
        chk("t6_unhalt", 64'(bus.halted[0]), 64'd0);
        chk("t6_start_wins", 64'(bus.address0), 64'h0600);
        step(); head(0, "t6_resume", 16'h6600, 16'h0600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
